// File: rtl/sd_sector_reader.sv
// Single-block read sequencer for sd_controller: issues the read, captures the
// returned bytes into a sector buffer with a running checksum, and reports done/timeout.
module sd_sector_reader #(
  parameter int SECTOR_BYTES = 512,
  parameter int BUF_AW       = 9,
  parameter int TIMEOUT      = 2**22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       sector,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [9:0]        byte_count,
  output logic [15:0]       checksum,
  input  logic              sd_ready,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  input  logic [BUF_AW-1:0] buf_raddr,
  output logic [7:0]        buf_rdata
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [9:0]      FULL   = 10'(SECTOR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_RECV,
    S_FINISH,
    S_DONE
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            bav_q;
  logic            capture;
  logic            active;
  logic            advance;
  logic            timeout;
  logic [7:0]      mem [2**BUF_AW];

  // Only a rising edge of the strobe captures; a level held high counts once.
  always_comb begin
    capture = 1'b0;
    active  = 1'b0;
    advance = 1'b0;
    case (state)
      S_WAIT_RDY: begin
        active  = 1'b1;
        advance = sd_ready;
      end
      S_ISSUE: begin
        active  = 1'b1;
        advance = !sd_ready;
      end
      S_RECV: begin
        active  = 1'b1;
        capture = sd_byte_available && !bav_q && (byte_count != FULL);
        advance = capture || (byte_count == FULL);
      end
      S_FINISH: begin
        active  = 1'b1;
        advance = sd_ready;
      end
      default: ;
    endcase
    timeout = active && !advance && (wd_cnt == WD_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wd_cnt     <= '0;
      bav_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      sd_rd      <= 1'b0;
      sd_address <= '0;
      byte_count <= '0;
      checksum   <= '0;
    end else begin
      bav_q <= sd_byte_available;
      done  <= 1'b0;
      if (active && !advance) wd_cnt <= wd_cnt + 1'b1;
      else                    wd_cnt <= '0;
      // Watchdog abort keeps the partial byte_count/checksum for the host to inspect.
      if (timeout) begin
        sd_rd <= 1'b0;
        error <= 1'b1;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              sd_address <= sector;
              byte_count <= '0;
              checksum   <= '0;
              error      <= 1'b0;
              busy       <= 1'b1;
              state      <= S_WAIT_RDY;
            end
          end
          S_WAIT_RDY: begin
            if (sd_ready) begin
              sd_rd <= 1'b1;
              state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (!sd_ready) begin
              sd_rd <= 1'b0;
              state <= S_RECV;
            end
          end
          S_RECV: begin
            if (byte_count == FULL) begin
              state <= S_FINISH;
            end else if (capture) begin
              byte_count <= byte_count + 10'd1;
              checksum   <= checksum + {8'd0, sd_dout};
            end
          end
          S_FINISH: begin
            if (sd_ready) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (capture) mem[byte_count[BUF_AW-1:0]] <= sd_dout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) buf_rdata <= '0;
    else        buf_rdata <= mem[buf_raddr];
  end

endmodule
